// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-segmented pipelined N-bit add/subtract with valid/ready streaming
// Optional signed saturation on the last stage when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int STAGES = (N + SEG - 1) / SEG;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0] valid, adv, load, v_nx;
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      bx_q[STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic              c_q [STAGES];
  logic [N-1:0]      a_nx [STAGES];
  logic [N-1:0]      bx_nx[STAGES];
  logic [N-1:0]      s_nx [STAGES];
  logic              c_nx [STAGES];
  logic              ovf_q, ovf_nx;

  logic [N-1:0] ai, bi, si;
  logic         c, ctop;
`ifdef ADDSUB_SAT_EN
  logic [N-1:0] min_v;
`endif

  // Ready chain runs from the output back to the input so a full stage can load while it drains.
  always_comb begin
    adv  = '0;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k == LAST) adv[k] = valid[k] & out_ready;
      else           adv[k] = valid[k] & load[(k < LAST) ? k + 1 : LAST];
      load[k] = ~valid[k] | adv[k];
    end
  end

  assign in_ready = load[0];

  always_comb begin
    ai     = '0;
    bi     = '0;
    si     = '0;
    c      = 1'b0;
    ctop   = 1'b0;
    ovf_nx = 1'b0;
    v_nx   = '0;
`ifdef ADDSUB_SAT_EN
    min_v        = '0;
    min_v[N-1]   = 1'b1;
`endif
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        ai      = a;
        bi      = b ^ {N{sub}};
        si      = '0;
        c       = sub;
        v_nx[k] = in_valid;
      end else begin
        ai      = a_q [(k > 0) ? k - 1 : 0];
        bi      = bx_q[(k > 0) ? k - 1 : 0];
        si      = s_q [(k > 0) ? k - 1 : 0];
        c       = c_q [(k > 0) ? k - 1 : 0];
        v_nx[k] = valid[(k > 0) ? k - 1 : 0];
      end
      // Resolve only this stage's slice; the rest of the beat passes through untouched.
      for (int j = 0; j < N; j++) begin
        if (j / SEG == k) begin
          if (j == N - 1) ctop = c;
          si[j] = ai[j] ^ bi[j] ^ c;
          c     = (ai[j] & bi[j]) | (c & (ai[j] ^ bi[j]));
        end
      end
      if (k == LAST) begin
        ovf_nx = ctop ^ c;
`ifdef ADDSUB_SAT_EN
        if (ovf_nx) si = ai[N-1] ? min_v : ~min_v;
`endif
      end
      a_nx[k]  = ai;
      bx_nx[k] = bi;
      s_nx[k]  = si;
      c_nx[k]  = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid[k] <= v_nx[k];
          if (v_nx[k]) begin
            a_q[k]  <= a_nx[k];
            bx_q[k] <= bx_nx[k];
            s_q[k]  <= s_nx[k];
            c_q[k]  <= c_nx[k];
          end
        end
      end
      if (load[LAST] && v_nx[LAST]) ovf_q <= ovf_nx;
    end
  end

  assign out_valid = valid[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (N=16/SEG=4, N=10/SEG=4, N=8/SEG=8)
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;
  logic        in_ready_b, out_valid_b, cout_b, ovf_b;
  logic [9:0]  sum_b;
  logic        in_ready_c, out_valid_c, cout_c, ovf_c;
  logic [7:0]  sum_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.N(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow));

  pipelined_addsub #(.N(10), .SEG(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .a(a[9:0]), .b(b[9:0]), .sub(sub), .out_valid(out_valid_b), .out_ready(1'b1),
    .sum(sum_b), .cout(cout_b), .overflow(ovf_b));

  pipelined_addsub #(.N(8), .SEG(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid_c), .out_ready(1'b1),
    .sum(sum_c), .cout(cout_c), .overflow(ovf_c));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  // Reference: unsigned sum for sum/cout, true signed arithmetic for overflow.
  function automatic res_t model(int n, longint av, longint bv, logic sv);
    longint mask = (64'sd1 <<< n) - 1;
    longint half = 64'sd1 <<< (n - 1);
    longint full, sa, sb, r;
    res_t   o;
    av   = av & mask;
    bv   = bv & mask;
    full = sv ? av + ((~bv) & mask) + 1 : av + bv;
    o.cout = ((full >>> n) & 1) != 0;
    sa = (av >= half) ? av - (mask + 1) : av;
    sb = (bv >= half) ? bv - (mask + 1) : bv;
    r  = sv ? sa - sb : sa + sb;
    o.ovf = (r >= half) || (r < -half);
    o.sum = 16'(full & mask);
`ifdef ADDSUB_SAT_EN
    if (o.ovf) o.sum = 16'((sa < 0) ? half : half - 1);
`endif
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated beat into all three units, capturing when and what each one offers.
  task automatic do_beat(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input string tag, output logic [15:0] s0, output logic c0,
                         output logic o0);
    res_t m0, m1, m2;
    int   lat0 = 0, lat1 = 0, lat2 = 0;
    logic [15:0] s1 = '0, s2 = '0;
    logic c1 = 1'b0, c2 = 1'b0, o1 = 1'b0, o2 = 1'b0;
    s0 = '0; c0 = 1'b0; o0 = 1'b0;
    @(negedge clk);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      if (out_valid   && lat0 == 0) begin lat0 = cyc; s0 = sum;   c0 = cout;   o0 = overflow; end
      if (out_valid_b && lat1 == 0) begin lat1 = cyc; s1 = 16'(sum_b); c1 = cout_b; o1 = ovf_b; end
      if (out_valid_c && lat2 == 0) begin lat2 = cyc; s2 = 16'(sum_c); c2 = cout_c; o2 = ovf_c; end
    end
    m0 = model(16, longint'(av), longint'(bv), sv);
    m1 = model(10, longint'(av), longint'(bv), sv);
    m2 = model(8,  longint'(av), longint'(bv), sv);
    check({tag, " lat16"},  lat0, 4);
    check({tag, " sum16"},  s0, m0.sum);
    check({tag, " cout16"}, c0, m0.cout);
    check({tag, " ovf16"},  o0, m0.ovf);
    check({tag, " lat10"},  lat1, 3);
    check({tag, " sum10"},  s1, m1.sum);
    check({tag, " cout10"}, c1, m1.cout);
    check({tag, " ovf10"},  o1, m1.ovf);
    check({tag, " lat8"},   lat2, 1);
    check({tag, " sum8"},   s2, m2.sum);
    check({tag, " cout8"},  c2, m2.cout);
  endtask

  res_t        q[$];
  res_t        exp_r;
  logic [15:0] rs;
  logic        rc, ro;
  logic        stalled;
  logic [15:0] held_sum;
  logic        held_cout, held_ovf;
  int          sent, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum",       sum, 16'h0000);
    check("reset cout",      cout, 1'b0);
    check("reset ovf",       overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release in_ready", in_ready, 1'b1);

    do_beat(16'h00FF, 16'h0001, 1'b0, "t1", rs, rc, ro);
    check("t1 const sum", rs, 16'h0100);
    do_beat(16'hFFFF, 16'h0001, 1'b0, "t2", rs, rc, ro);
    check("t2 const sum", rs, 16'h0000);
    check("t2 const cout", rc, 1'b1);
    do_beat(16'h0005, 16'h0007, 1'b1, "t3a", rs, rc, ro);
    check("t3a const sum", rs, 16'hFFFE);
    check("t3a const cout", rc, 1'b0);
    do_beat(16'h8000, 16'h0001, 1'b1, "t3b", rs, rc, ro);
    check("t3b const ovf", ro, 1'b1);
    check("t3b const cout", rc, 1'b1);
    do_beat(16'h7FFF, 16'h0001, 1'b0, "t4", rs, rc, ro);
    check("t4 const ovf", ro, 1'b1);
`ifdef ADDSUB_SAT_EN
    check("t4 const sum", rs, 16'h7FFF);
`else
    check("t4 const sum", rs, 16'h8000);
`endif

    // Random streaming with random backpressure against a FIFO scoreboard.
    sent = 0; stalled = 1'b0; held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    for (int cyc = 0; cyc < 2000 && (sent < 60 || q.size() > 0); cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 60);
      a         = 16'($urandom);
      b         = 16'($urandom);
      sub       = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        check("stall out_valid", out_valid, 1'b1);
        check("stall sum",       sum, held_sum);
        check("stall cout",      cout, held_cout);
        check("stall ovf",       overflow, held_ovf);
      end
      check("in_ready rule", in_ready, !(q.size() == 4 && !out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected beat", 1'b1, 1'b0);
        end else begin
          exp_r = q.pop_front();
          check("rand sum",  sum, exp_r.sum);
          check("rand cout", cout, exp_r.cout);
          check("rand ovf",  overflow, exp_r.ovf);
        end
      end
      stalled   = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
      held_ovf  = overflow;
      if (in_valid && in_ready) begin
        q.push_back(model(16, longint'(a), longint'(b), sub));
        sent++;
      end
    end
    check("rand all sent", sent, 60);
    check("rand drained", q.size(), 0);

    // Reset with three beats in flight and the output stalled.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset sum",       sum, 16'h0000);
    check("midreset ovf",       overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 check("post reset in_ready", in_ready, 1'b1);
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid || out_valid_b || out_valid_c) seen++;
    end
    check("no stale beats", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
